dnn_layer_sequencer: RTL and testbench

Sequences one shared 4-input output neuron (12-bit activations × 5-bit signed weights → 17-bit signed result, one register stage) across `NUM_OUT` output neurons of a DNN layer. On `start`, the block latches four input activations and streams each neuron's weights from a synchronous weight ROM into the shared neuron. It collects every result into an output bank and signals `done`. It sits between the hidden-layer outputs and the classifier/argmax stage.

---
 rtl/dnn_pkg.sv | 23 ++
 rtl/dnn_layer_sequencer_chk.sv | 16 +
 rtl/dnn_layer_sequencer_result_bank.sv | 34 +++
 rtl/dnn_layer_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_dnn_layer_sequencer.sv | 332 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dnn_pkg.sv
// Shared widths, sequencer state encoding and vector types for the DNN layer datapath.
package dnn_pkg;

  localparam int ACT_W = 12;
  localparam int WT_W  = 5;
  localparam int RES_W = 17;
  localparam int N_IN  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } seq_state_t;

  typedef logic signed [ACT_W-1:0] act_t;
  typedef logic signed [WT_W-1:0]  wt_t;
  typedef logic signed [RES_W-1:0] res_t;

  typedef act_t [N_IN-1:0] act_vec_t;
  typedef wt_t  [N_IN-1:0] wt_vec_t;

endpackage

// File: rtl/dnn_layer_sequencer_chk.sv
// Simulation-only protocol checks for the layer sequencer's neuron result handshake.
module dnn_layer_sequencer_chk (
  input logic clk,
  input logic rst_n,
  input logic in_idle,
  input logic cap_full,
  input logic n_result_ready
);

  // A neuron result with no free capture slot would be silently lost
  a_no_stray_result: assert property (
    @(posedge clk) disable iff (!rst_n)
      n_result_ready |-> !(in_idle || cap_full)
  );

endmodule

// File: rtl/dnn_layer_sequencer_result_bank.sv
// Indexed capture register array holding one neuron result per entry.
module result_bank
  import dnn_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             we,
  input  logic [IDX_W-1:0] idx,
  input  res_t             wdata,
  output res_t [DEPTH-1:0] bank
);

  res_t [DEPTH-1:0] bank_r;

  // Clear wipes every entry; a write updates only the indexed entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_r <= '0;
    end else if (clear) begin
      bank_r <= '0;
    end else if (we) begin
      bank_r[idx] <= wdata;
    end else begin
      bank_r <= bank_r;
    end
  end

  assign bank = bank_r;

endmodule

// File: rtl/dnn_layer_sequencer.sv
// Sequences one shared 4-input neuron across NUM_OUT output neurons: issues ROM reads,
// feeds weights and latched activations to the neuron, and captures results in order.
module dnn_layer_sequencer
  import dnn_pkg::*;
#(
  parameter int NUM_OUT = 4,
  parameter int IDX_W   = $clog2(NUM_OUT)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  act_vec_t           act_in,
  output logic               busy,
  output logic               done,
  output logic               wt_rd_en,
  output logic [IDX_W-1:0]   wt_addr,
  input  wt_vec_t            wt_data,
  output logic               n_input_ready,
  output act_t               n_in0,
  output act_t               n_in1,
  output act_t               n_in2,
  output act_t               n_in3,
  output wt_t                n_w0,
  output wt_t                n_w1,
  output wt_t                n_w2,
  output wt_t                n_w3,
  input  logic               n_result_ready,
  input  res_t               n_result,
  output res_t [NUM_OUT-1:0] res_bank,
  output logic               res_valid
);

  // The capture index must be able to reach NUM_OUT, one past the last entry
  localparam int CNT_W = IDX_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OUT - 1);
  localparam logic [CNT_W-1:0] CAP_FULL = CNT_W'(NUM_OUT);
  localparam logic [CNT_W-1:0] CAP_LAST = CNT_W'(NUM_OUT - 1);

  seq_state_t       state_r, state_nxt_s;
  logic [IDX_W-1:0] issue_idx_r, issue_idx_nxt_s;
  logic [CNT_W-1:0] cap_idx_r, cap_idx_nxt_s;
  logic             busy_r, busy_nxt_s;
  logic             done_r, done_nxt_s;
  logic             rd_en_r, rd_en_nxt_s;
  logic             res_valid_r, res_valid_nxt_s;
  logic             rd_vld_r;
  act_vec_t         act_r, act_nxt_s;
  logic             cap_we_s, cap_last_s, cap_full_s;
  wt_vec_t          feed_w_s;

  // Capture qualification: results are only accepted into a free slot of an active pass
  always_comb begin
    cap_full_s = (cap_idx_r == CAP_FULL);
    cap_we_s   = n_result_ready && (state_r != IDLE) && !cap_full_s;
    cap_last_s = cap_we_s && (cap_idx_r == CAP_LAST);
  end

  // Next-state and next-register values for the pass controller
  always_comb begin
    state_nxt_s     = state_r;
    issue_idx_nxt_s = issue_idx_r;
    cap_idx_nxt_s   = cap_we_s ? (cap_idx_r + CNT_W'(1)) : cap_idx_r;
    busy_nxt_s      = busy_r;
    done_nxt_s      = 1'b0;
    rd_en_nxt_s     = rd_en_r;
    res_valid_nxt_s = res_valid_r;
    act_nxt_s       = act_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nxt_s     = ISSUE;
          issue_idx_nxt_s = '0;
          cap_idx_nxt_s   = '0;
          busy_nxt_s      = 1'b1;
          rd_en_nxt_s     = 1'b1;
          res_valid_nxt_s = 1'b0;
          act_nxt_s       = act_in;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ISSUE: begin
        if (issue_idx_r == LAST_IDX) begin
          state_nxt_s = DRAIN;
          rd_en_nxt_s = 1'b0;
        end else begin
          issue_idx_nxt_s = issue_idx_r + IDX_W'(1);
        end
      end
      DRAIN: begin
        // Finish on the edge that captures the last result so done lands right after it
        if (cap_last_s || cap_full_s) begin
          state_nxt_s     = DONE;
          done_nxt_s      = 1'b1;
          res_valid_nxt_s = 1'b1;
        end else begin
          state_nxt_s = DRAIN;
        end
      end
      DONE: begin
        state_nxt_s = IDLE;
        busy_nxt_s  = 1'b0;
      end
      default: begin
        state_nxt_s = IDLE;
        busy_nxt_s  = 1'b0;
        rd_en_nxt_s = 1'b0;
      end
    endcase
  end

  // Controller state, indices, latched activations and the ROM-read valid delay
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      issue_idx_r <= '0;
      cap_idx_r   <= '0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      rd_en_r     <= 1'b0;
      res_valid_r <= 1'b0;
      act_r       <= '0;
      rd_vld_r    <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      issue_idx_r <= issue_idx_nxt_s;
      cap_idx_r   <= cap_idx_nxt_s;
      busy_r      <= busy_nxt_s;
      done_r      <= done_nxt_s;
      rd_en_r     <= rd_en_nxt_s;
      res_valid_r <= res_valid_nxt_s;
      act_r       <= act_nxt_s;
      rd_vld_r    <= rd_en_r;
    end
  end

  // ROM data arrives a cycle after the read, so weights pass straight through when valid
  always_comb begin
    if (rd_vld_r) begin
      feed_w_s = wt_data;
    end else begin
      feed_w_s = '0;
    end
  end

  result_bank #(
    .DEPTH (NUM_OUT),
    .IDX_W (IDX_W)
  ) u_result_bank (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (1'b0),
    .we    (cap_we_s),
    .idx   (cap_idx_r[IDX_W-1:0]),
    .wdata (n_result),
    .bank  (res_bank)
  );

  dnn_layer_sequencer_chk u_chk (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_idle        (state_r == IDLE),
    .cap_full       (cap_full_s),
    .n_result_ready (n_result_ready)
  );

  assign busy          = busy_r;
  assign done          = done_r;
  assign wt_rd_en      = rd_en_r;
  assign wt_addr       = issue_idx_r;
  assign res_valid     = res_valid_r;
  assign n_input_ready = rd_vld_r;
  assign n_in0         = act_r[0];
  assign n_in1         = act_r[1];
  assign n_in2         = act_r[2];
  assign n_in3         = act_r[3];
  assign n_w0          = feed_w_s[0];
  assign n_w1          = feed_w_s[1];
  assign n_w2          = feed_w_s[2];
  assign n_w3          = feed_w_s[3];

endmodule

// File: tb/tb_dnn_layer_sequencer.sv
// Self-checking bench: timeline-based reference model for NUM_OUT=4 plus an NUM_OUT=16 overflow pass.
module tb_dnn_layer_sequencer;
  import dnn_pkg::*;

  localparam int N = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- NUM_OUT=4 instance ----------------
  logic           start = 1'b0;
  act_vec_t       act_in = '0;
  logic           busy, done, wt_rd_en, n_input_ready, res_valid;
  logic [1:0]     wt_addr;
  wt_vec_t        wt_data = '0;
  act_t           n_in0, n_in1, n_in2, n_in3;
  wt_t            n_w0, n_w1, n_w2, n_w3;
  logic           n_result_ready;
  res_t           n_result;
  res_t [N-1:0]   res_bank;
  act_vec_t       nin_v;
  wt_vec_t        nw_v;

  assign nin_v = {n_in3, n_in2, n_in1, n_in0};
  assign nw_v  = {n_w3, n_w2, n_w1, n_w0};

  dnn_layer_sequencer #(.NUM_OUT(N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .act_in(act_in),
    .busy(busy), .done(done), .wt_rd_en(wt_rd_en), .wt_addr(wt_addr), .wt_data(wt_data),
    .n_input_ready(n_input_ready),
    .n_in0(n_in0), .n_in1(n_in1), .n_in2(n_in2), .n_in3(n_in3),
    .n_w0(n_w0), .n_w1(n_w1), .n_w2(n_w2), .n_w3(n_w3),
    .n_result_ready(n_result_ready), .n_result(n_result),
    .res_bank(res_bank), .res_valid(res_valid)
  );

  // ROM contents: 0 -> {1,2,-3,k}, 1 -> {k,0,0,0}, 2 -> random table
  int rom_mode = 0;
  int rand_rows [N][4];

  function automatic int row_w(input int k, input int j);
    if (rom_mode == 0) return (j == 0) ? 1 : (j == 1) ? 2 : (j == 2) ? -3 : k;
    else if (rom_mode == 1) return (j == 0) ? k : 0;
    else return rand_rows[k][j];
  endfunction

  function automatic int mac(input act_vec_t a, input wt_vec_t w);
    int s = 0;
    for (int j = 0; j < 4; j++) s += $signed(a[j]) * $signed(w[j]);
    return s;
  endfunction

  always @(posedge clk) begin
    if (wt_rd_en) for (int j = 0; j < 4; j++) wt_data[j] <= wt_t'(row_w(int'(wt_addr), j));
  end

  // External neuron: one register stage
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_result_ready <= 1'b0;
      n_result       <= '0;
    end else begin
      n_result_ready <= n_input_ready;
      n_result       <= res_t'(mac(nin_v, nw_v));
    end
  end

  // Reference model: m_t counts edges since the accepting edge (-1 when idle)
  int       m_t = -1;
  int       m_addr = 0;
  bit       m_rv = 1'b0;
  act_vec_t m_act = '0;
  res_t     m_bank [N];

  function automatic int dot(input int k);
    int s = 0;
    for (int j = 0; j < 4; j++) s += $signed(m_act[j]) * row_w(k, j);
    return s;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_t    <= -1;
      m_addr <= 0;
      m_rv   <= 1'b0;
      m_act  <= '0;
      for (int k = 0; k < N; k++) m_bank[k] <= '0;
    end else if (m_t >= 0) begin
      if (m_t + 1 <= N - 1) m_addr <= m_t + 1;
      if (m_t - 2 >= 0 && m_t - 2 < N) m_bank[m_t-2] <= res_t'(dot(m_t - 2));
      if (m_t + 1 == N + 2) m_rv <= 1'b1;
      m_t <= (m_t + 1 > N + 2) ? -1 : m_t + 1;
    end else if (start) begin
      m_t    <= 0;
      m_addr <= 0;
      m_rv   <= 1'b0;
      m_act  <= act_in;
    end
  end

  bit cmp_en = 1'b0;

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("busy", busy, m_t >= 0);
      chk("done", done, m_t == N + 2);
      chk("wt_rd_en", wt_rd_en, m_t >= 0 && m_t < N);
      chk("wt_addr", wt_addr, m_addr);
      chk("n_input_ready", n_input_ready, m_t >= 1 && m_t <= N);
      chk("res_valid", res_valid, m_rv);
      for (int j = 0; j < 4; j++) begin
        chk($sformatf("n_w%0d", j), $signed(nw_v[j]), (m_t >= 1 && m_t <= N) ? row_w(m_t - 1, j) : 0);
        chk($sformatf("n_in%0d", j), $signed(nin_v[j]), $signed(m_act[j]));
      end
      for (int k = 0; k < N; k++) chk($sformatf("res_bank%0d", k), $signed(res_bank[k]), m_bank[k]);
    end
  end

  int done_at, busy_cnt, rdy_first, rdy_cnt;

  task automatic start_pass(input act_vec_t a);
    @(posedge clk); #2;
    act_in = a;
    start  = 1'b1;
    @(posedge clk); #2;
    start  = 1'b0;
  endtask

  // mode 0: plain, 1: extra start after E2, 2: return after E3 for a reset
  task automatic watch(input int mode, input act_vec_t alt);
    done_at = -1; busy_cnt = 0; rdy_first = -1; rdy_cnt = 0;
    for (int c = 0; c < 40 && done_at < 0; c++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (n_input_ready) begin
        if (rdy_first < 0) rdy_first = c;
        rdy_cnt++;
      end
      if (done) done_at = c;
      if (mode == 1 && c == 2) begin start = 1'b1; act_in = alt; end
      if (mode == 1 && c == 3) start = 1'b0;
      if (mode == 2 && c == 3) return;
    end
    if (done_at < 0) chk("done_timeout", done_at, N + 2);
  endtask

  task automatic chk_bank(input string name, input int e0, input int e1, input int e2, input int e3);
    chk({name, "0"}, $signed(res_bank[0]), e0);
    chk({name, "1"}, $signed(res_bank[1]), e1);
    chk({name, "2"}, $signed(res_bank[2]), e2);
    chk({name, "3"}, $signed(res_bank[3]), e3);
  endtask

  // ---------------- NUM_OUT=16 instance ----------------
  logic          start16 = 1'b0;
  act_vec_t      act16 = '0;
  logic          busy16, done16, rd16, rdy16, rr16, rv16;
  logic [3:0]    addr16;
  wt_vec_t       wd16 = '0;
  act_t          i16_0, i16_1, i16_2, i16_3;
  wt_t           w16_0, w16_1, w16_2, w16_3;
  res_t          rs16;
  res_t [15:0]   bank16;

  dnn_layer_sequencer #(.NUM_OUT(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .act_in(act16),
    .busy(busy16), .done(done16), .wt_rd_en(rd16), .wt_addr(addr16), .wt_data(wd16),
    .n_input_ready(rdy16),
    .n_in0(i16_0), .n_in1(i16_1), .n_in2(i16_2), .n_in3(i16_3),
    .n_w0(w16_0), .n_w1(w16_1), .n_w2(w16_2), .n_w3(w16_3),
    .n_result_ready(rr16), .n_result(rs16),
    .res_bank(bank16), .res_valid(rv16)
  );

  always @(posedge clk) begin
    if (rd16) wd16 <= {4{5'b10000}};
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr16 <= 1'b0;
      rs16 <= '0;
    end else begin
      rr16 <= rdy16;
      rs16 <= res_t'(mac({i16_3, i16_2, i16_1, i16_0}, {w16_3, w16_2, w16_1, w16_0}));
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    act_vec_t a, a2;
    act_vec_t a16 [3];
    int e16 [3];
    int extra, d, b;

    repeat (3) @(posedge clk);
    #2;
    cmp_en = 1'b1;
    chk("rst_busy", busy, 0);
    chk("rst_wt_rd_en", wt_rd_en, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_bank0", $signed(res_bank[0]), 0);
    rst_n = 1'b1;

    // Basic pass: every row gives 100-100-21+0 = -21
    rom_mode = 0;
    a = {12'sd0, 12'sd7, -12'sd50, 12'sd100};
    start_pass(a);
    watch(0, a);
    chk("basic_done_cycle", done_at, 6);
    chk("basic_busy_cycles", busy_cnt, 7);
    chk_bank("basic_bank", -21, -21, -21, -21);

    // Distinct rows, then a start in the done cycle (dropped) followed by an accepted one
    rom_mode = 1;
    a  = {12'sd0, 12'sd0, 12'sd0, -12'sd2048};
    a2 = {12'sd0, 12'sd0, 12'sd0, -12'sd1000};
    start_pass(a);
    watch(0, a);
    chk("rows_rdy_first", rdy_first, 1);
    chk("rows_rdy_cnt", rdy_cnt, 4);
    chk_bank("rows_bank", 0, -2048, -4096, -6144);
    act_in = a2;
    start  = 1'b1;
    @(posedge clk); #1;
    chk("b2b_drop_busy", busy, 0);
    chk("b2b_drop_valid", res_valid, 1);
    @(posedge clk); #1;
    chk("b2b_accept_busy", busy, 1);
    chk("b2b_valid_fall", res_valid, 0);
    #1 start = 1'b0;
    watch(0, a2);
    chk("b2b_done_cycle", done_at, 6);
    chk_bank("b2b_bank", 0, -1000, -2000, -3000);

    // Start while busy: second activations must be ignored
    rom_mode = 0;
    a  = {4{12'sd1}};
    a2 = {12'sd0, 12'sd7, -12'sd50, 12'sd100};
    start_pass(a);
    watch(1, a2);
    chk_bank("busy_start_bank", 0, 1, 2, 3);
    extra = 0;
    repeat (6) begin
      @(negedge clk);
      if (done) extra++;
    end
    chk("busy_start_single_done", extra, 0);

    // Reset in the middle of a pass
    a = {4{12'sd10}};
    start_pass(a);
    watch(2, a);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_wt_rd_en", wt_rd_en, 0);
    chk("midrst_wt_addr", wt_addr, 0);
    chk("midrst_ready", n_input_ready, 0);
    chk("midrst_n_in0", $signed(n_in0), 0);
    chk("midrst_res_valid", res_valid, 0);
    chk_bank("midrst_bank", 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    start_pass(a);
    watch(0, a);
    chk("postrst_done_cycle", done_at, 6);
    chk_bank("postrst_bank", 0, 10, 20, 30);

    // Randomized passes against the model
    rom_mode = 2;
    for (int p = 0; p < 20; p++) begin
      for (int k = 0; k < N; k++)
        for (int j = 0; j < 4; j++) rand_rows[k][j] = int'($urandom_range(31, 0)) - 16;
      for (int j = 0; j < 4; j++) begin
        a[j]  = act_t'($urandom_range(4095, 0));
        a2[j] = act_t'($urandom_range(4095, 0));
      end
      repeat ($urandom_range(3, 0)) @(posedge clk);
      start_pass(a);
      watch(int'($urandom_range(1, 0)), a2);
      chk("rand_done_cycle", done_at, N + 2);
    end
    repeat (4) @(posedge clk);

    // NUM_OUT=16 with weights all -16; sums 32768, 98304 and 131072 wrap modulo 2^17
    a16[0] = {12'sd0, 12'sd0, 12'sd0, -12'sd2048};
    a16[1] = {12'sd0, -12'sd2048, -12'sd2048, -12'sd2048};
    a16[2] = {4{-12'sd2048}};
    e16[0] = 32768;
    e16[1] = -32768;
    e16[2] = 0;
    for (int p = 0; p < 3; p++) begin
      @(posedge clk); #2;
      act16   = a16[p];
      start16 = 1'b1;
      @(posedge clk); #2;
      start16 = 1'b0;
      d = -1;
      b = 0;
      for (int c = 0; c < 40 && d < 0; c++) begin
        @(negedge clk);
        if (busy16) b++;
        if (done16) d = c;
      end
      chk("n16_done_cycle", d, 18);
      chk("n16_busy_cycles", b, 19);
      chk("n16_res_valid", rv16, 1);
      chk("n16_wt_addr_hold", addr16, 15);
      for (int k = 0; k < 16; k++) chk($sformatf("n16_bank%0d", k), $signed(bank16[k]), e16[p]);
      repeat (2) @(posedge clk);
    end

    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
